// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle sequencer (master) and the MIPS datapath (slave).
// Carries instruction and handshake inputs plus every select, enable, strobe and status flag.
interface multicycle_control_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        pc_en;
   logic [1:0]  pc_src;
   logic        iord;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        reg_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [3:0]  alu_op;
   logic [3:0]  state;
   logic        halted;
   logic        illegal;
   logic        bus_error;
   logic        retired;

   modport master (
      input  instr, zero, mem_ready,
      output pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, state,
             halted, illegal, bus_error, retired
   );

   modport slave (
      output instr, zero, mem_ready,
      input  pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, state,
             halted, illegal, bus_error, retired
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: lw 5, sw/R-type/addi 4, beq/bne/j 3 cycles plus one per memory wait cycle.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; halts on instr==0, unsupported decode or wait timeout.
module multicycle_control #(
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      HALT   = 4'd15
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          illegal_q, illegal_d;
   logic          bus_error_q, bus_error_d;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       wait_state;
   logic       timeout;
   logic       illegal_set;
   logic       funct_ok;
   logic       unused_instr;

   assign opcode       = bus.instr[31:26];
   assign funct        = bus.instr[5:0];
   assign unused_instr = ^bus.instr[25:6];

   assign wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
   // Completion beats the limit: timeout only fires while mem_ready is still low.
   assign timeout    = (TIMEOUT != 0) && wait_state && !bus.mem_ready && (wait_cnt_q == WAIT_LIMIT);

   always_comb begin
      funct_ok = 1'b0;
      case (funct)
         6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: funct_ok = 1'b1;
         default:                           funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      illegal_set    = 1'b0;
      bus.pc_en      = 1'b0;
      bus.pc_src     = 2'd0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'd0;
      bus.alu_op     = ALU_AND;
      bus.retired    = 1'b0;

      case (state_q)
         FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'd1;
            bus.alu_op    = ALU_ADD;
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_en    = 1'b1;
               state_d      = DECODE;
            end else if (timeout) begin
               state_d = HALT;
            end
         end
         DECODE: begin
            bus.alu_src_b = 2'd3;
            bus.alu_op    = ALU_ADD;
            case (opcode)
               OP_RTYPE: begin
                  if (funct_ok) begin
                     state_d = EXEC;
                  end else begin
                     state_d     = HALT;
                     illegal_set = (bus.instr != 32'd0);
                  end
               end
               OP_LW, OP_SW:   state_d = MEMADR;
               OP_BEQ, OP_BNE: state_d = BRANCH;
               OP_ADDI:        state_d = ADDIEX;
               OP_J:           state_d = JUMP;
               default: begin
                  state_d     = HALT;
                  illegal_set = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            bus.alu_op    = ALU_ADD;
            state_d       = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
            if (bus.mem_ready) begin
               state_d = MEMWB;
            end else if (timeout) begin
               state_d = HALT;
            end
         end
         MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            bus.retired    = 1'b1;
            state_d        = FETCH;
         end
         MEMWR: begin
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
            if (bus.mem_ready) begin
               bus.retired = 1'b1;
               state_d     = FETCH;
            end else if (timeout) begin
               state_d = HALT;
            end
         end
         EXEC: begin
            bus.alu_src_a = 1'b1;
            case (funct)
               6'h22:   bus.alu_op = ALU_SUB;
               6'h24:   bus.alu_op = ALU_AND;
               6'h25:   bus.alu_op = ALU_OR;
               6'h2a:   bus.alu_op = ALU_SLT;
               default: bus.alu_op = ALU_ADD;
            endcase
            state_d = ALUWB;
         end
         ALUWB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            bus.retired   = 1'b1;
            state_d       = FETCH;
         end
         ADDIEX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            bus.alu_op    = ALU_ADD;
            state_d       = ADDIWB;
         end
         ADDIWB: begin
            bus.reg_write = 1'b1;
            bus.retired   = 1'b1;
            state_d       = FETCH;
         end
         BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_SUB;
            bus.pc_src    = 2'd1;
            // ALUOut already holds the target computed during DECODE.
            bus.pc_en     = (opcode == OP_BNE) ? ~bus.zero : bus.zero;
            bus.retired   = 1'b1;
            state_d       = FETCH;
         end
         JUMP: begin
            bus.pc_src  = 2'd2;
            bus.pc_en   = 1'b1;
            bus.retired = 1'b1;
            state_d     = FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = HALT;
         end
      endcase

      // Reset parks the FSM in FETCH asynchronously; keep every write-type strobe quiet meanwhile.
      if (reset) begin
         bus.ir_write  = 1'b0;
         bus.pc_en     = 1'b0;
         bus.reg_write = 1'b0;
         bus.mem_write = 1'b0;
         bus.retired   = 1'b0;
      end
   end

   always_comb begin
      illegal_d   = illegal_q | illegal_set;
      bus_error_d = bus_error_q | timeout;
      if ((state_d != state_q) || bus.mem_ready || !wait_state) begin
         wait_cnt_d = '0;
      end else begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FETCH;
         wait_cnt_q  <= '0;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         illegal_q   <= illegal_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.halted    = (state_q == HALT);
   assign bus.illegal   = illegal_q;
   assign bus.bus_error = bus_error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected state/controls,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

   localparam logic [3:0] A_AND = 4'd0;
   localparam logic [3:0] A_ADD = 4'd2;
   localparam logic [3:0] A_SUB = 4'd6;
   localparam logic [3:0] A_SLT = 4'd7;

   localparam logic [31:0] I_LW   = 32'h8C080004;
   localparam logic [31:0] I_SW   = 32'hAC080004;
   localparam logic [31:0] I_SLT  = 32'h0109502A;
   localparam logic [31:0] I_BEQ  = 32'h10000003;
   localparam logic [31:0] I_BNE  = 32'h14000003;
   localparam logic [31:0] I_ADDI = 32'h21080005;
   localparam logic [31:0] I_J    = 32'h08000010;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [20:0] ctl;
   } exp_t;

   logic clk;
   logic reset;
   multicycle_control_if bus ();

   multicycle_control #(.TIMEOUT(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [20:0] VF_W, VF_R, VDEC, VMADR, VMRD, VMWB, VMWR_W, VMWR_R, VEX_SLT;
   logic [20:0] VALUWB, VADDIEX, VADDIWB, VBR_T, VBR_N, VJ, VHALT, VHALT_IL, VHALT_BE;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [20:0] cv(input logic pe, input logic [1:0] ps, input logic io,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic rd, input logic m2r, input logic rw,
                                      input logic sa, input logic [1:0] sb, input logic [3:0] op,
                                      input logic h, input logic il, input logic be,
                                      input logic ret);
      return {pe, ps, io, mr, mw, irw, rd, m2r, rw, sa, sb, op, h, il, be, ret};
   endfunction

   function automatic logic [20:0] actual_ctl();
      return {bus.pc_en, bus.pc_src, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
              bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.halted, bus.illegal, bus.bus_error, bus.retired};
   endfunction

   // Drive this cycle's inputs just after the edge and queue what the DUT must show.
   task automatic step(input string tag, input logic r, input logic [31:0] ins, input logic z,
                       input logic mr, input logic [3:0] st, input logic [20:0] v);
      exp_t e;
      @(posedge clk);
      #1;
      reset         = r;
      bus.instr     = ins;
      bus.zero      = z;
      bus.mem_ready = mr;
      e.tag = tag;
      e.st  = st;
      e.ctl = v;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         exp_t e;
         logic [20:0] a;
         e = sb_q.pop_front();
         a = actual_ctl();
         checks++;
         if (bus.state !== e.st) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", e.tag, bus.state, e.st);
         end
         checks++;
         if (a !== e.ctl) begin
            errors++;
            $display("FAIL %s controls: got %06h expected %06h", e.tag, a, e.ctl);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      bus.instr     = 32'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;

      VF_W     = cv(0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, A_ADD, 0, 0, 0, 0);
      VF_R     = cv(1, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, A_ADD, 0, 0, 0, 0);
      VDEC     = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, A_ADD, 0, 0, 0, 0);
      VMADR    = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, A_ADD, 0, 0, 0, 0);
      VMRD     = cv(0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, A_AND, 0, 0, 0, 0);
      VMWB     = cv(0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, A_AND, 0, 0, 0, 1);
      VMWR_W   = cv(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, A_AND, 0, 0, 0, 0);
      VMWR_R   = cv(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, A_AND, 0, 0, 0, 1);
      VEX_SLT  = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, A_SLT, 0, 0, 0, 0);
      VALUWB   = cv(0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, A_AND, 0, 0, 0, 1);
      VADDIEX  = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, A_ADD, 0, 0, 0, 0);
      VADDIWB  = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, A_AND, 0, 0, 0, 1);
      VBR_T    = cv(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, A_SUB, 0, 0, 0, 1);
      VBR_N    = cv(0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, A_SUB, 0, 0, 0, 1);
      VJ       = cv(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, A_AND, 0, 0, 0, 1);
      VHALT    = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, A_AND, 1, 0, 0, 0);
      VHALT_IL = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, A_AND, 1, 1, 0, 0);
      VHALT_BE = cv(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, A_AND, 1, 0, 1, 0);

      // Reset holds ir_write/pc_en low even with mem_ready high.
      step("rst",     1, 32'd0, 0, 1, 4'd0, VF_W);
      step("lw_f",    0, I_LW,  0, 1, 4'd0, VF_R);
      step("lw_d",    0, I_LW,  0, 1, 4'd1, VDEC);
      step("lw_a",    0, I_LW,  0, 1, 4'd2, VMADR);
      step("lw_r",    0, I_LW,  0, 1, 4'd3, VMRD);
      step("lw_wb",   0, I_LW,  0, 1, 4'd4, VMWB);

      for (int i = 0; i < 3; i++) step("fetch_wait", 0, I_SLT, 0, 0, 4'd0, VF_W);
      step("fetch_rdy", 0, I_SLT, 0, 1, 4'd0, VF_R);
      step("slt_d",   0, I_SLT, 0, 1, 4'd1, VDEC);
      step("slt_ex",  0, I_SLT, 0, 1, 4'd6, VEX_SLT);
      step("slt_wb",  0, I_SLT, 0, 1, 4'd7, VALUWB);

      step("beq1_f",  0, I_BEQ, 1, 1, 4'd0, VF_R);
      step("beq1_d",  0, I_BEQ, 1, 1, 4'd1, VDEC);
      step("beq1_br", 0, I_BEQ, 1, 1, 4'd8, VBR_T);
      step("beq0_f",  0, I_BEQ, 0, 1, 4'd0, VF_R);
      step("beq0_d",  0, I_BEQ, 0, 1, 4'd1, VDEC);
      step("beq0_br", 0, I_BEQ, 0, 1, 4'd8, VBR_N);
      step("bne0_f",  0, I_BNE, 0, 1, 4'd0, VF_R);
      step("bne0_d",  0, I_BNE, 0, 1, 4'd1, VDEC);
      step("bne0_br", 0, I_BNE, 0, 1, 4'd8, VBR_T);
      step("bne1_f",  0, I_BNE, 1, 1, 4'd0, VF_R);
      step("bne1_d",  0, I_BNE, 1, 1, 4'd1, VDEC);
      step("bne1_br", 0, I_BNE, 1, 1, 4'd8, VBR_N);

      step("sw_f",    0, I_SW,  0, 1, 4'd0, VF_R);
      step("sw_d",    0, I_SW,  0, 1, 4'd1, VDEC);
      step("sw_a",    0, I_SW,  0, 1, 4'd2, VMADR);
      step("sw_wait", 0, I_SW,  0, 0, 4'd5, VMWR_W);
      step("sw_done", 0, I_SW,  0, 1, 4'd5, VMWR_R);

      step("addi_f",  0, I_ADDI, 0, 1, 4'd0, VF_R);
      step("addi_d",  0, I_ADDI, 0, 1, 4'd1, VDEC);
      step("addi_ex", 0, I_ADDI, 0, 1, 4'd10, VADDIEX);
      step("addi_wb", 0, I_ADDI, 0, 1, 4'd11, VADDIWB);

      step("j_f",     0, I_J,   0, 1, 4'd0, VF_R);
      step("j_d",     0, I_J,   0, 1, 4'd1, VDEC);
      step("j_j",     0, I_J,   0, 1, 4'd9, VJ);

      // Wait counter runs 0..4 in MEMRD; the cycle at 4 sends the FSM to HALT.
      step("to_f",    0, I_LW,  0, 1, 4'd0, VF_R);
      step("to_d",    0, I_LW,  0, 1, 4'd1, VDEC);
      step("to_a",    0, I_LW,  0, 1, 4'd2, VMADR);
      for (int i = 0; i < 5; i++) step("to_rd", 0, I_LW, 0, 0, 4'd3, VMRD);
      step("to_halt", 0, I_LW,  0, 0, 4'd15, VHALT_BE);
      step("to_hold", 0, I_LW,  0, 1, 4'd15, VHALT_BE);

      step("rst2",    1, I_SW,  0, 0, 4'd0, VF_W);
      step("sw2_f",   0, I_SW,  0, 1, 4'd0, VF_R);
      step("sw2_d",   0, I_SW,  0, 1, 4'd1, VDEC);
      step("sw2_a",   0, I_SW,  0, 1, 4'd2, VMADR);
      step("sw2_wait",0, I_SW,  0, 0, 4'd5, VMWR_W);
      // Reset raised between edges while still in MEMWR.
      step("rst_mwr", 1, I_SW,  0, 0, 4'd0, VF_W);
      step("rel_f",   0, 32'd0, 0, 1, 4'd0, VF_R);
      step("zero_d",  0, 32'd0, 0, 1, 4'd1, VDEC);
      step("zero_h",  0, 32'd0, 0, 1, 4'd15, VHALT);
      step("zero_h2", 0, 32'd0, 0, 1, 4'd15, VHALT);

      step("rst3",    1, I_BAD, 0, 1, 4'd0, VF_W);
      step("bad_f",   0, I_BAD, 0, 1, 4'd0, VF_R);
      step("bad_d",   0, I_BAD, 0, 1, 4'd1, VDEC);
      step("bad_h",   0, I_BAD, 0, 1, 4'd15, VHALT_IL);
      step("bad_h2",  0, I_BAD, 1, 1, 4'd15, VHALT_IL);
      step("rst4",    1, I_BAD, 0, 0, 4'd0, VF_W);
      step("rel4",    0, I_LW,  0, 0, 4'd0, VF_W);

      for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS datapath: one FSM that steps a shared ALU, register file and a single unified memory port through fetch, decode, execute, memory and write-back for each instruction. It replaces per-instruction single-cycle decode, generates every datapath select and enable, waits on a memory ready handshake, and halts on an all-zero instruction, an unsupported instruction or a memory timeout. ALU operation codes are the `ALU_*` codes from mips.h.

## Interface
- TIMEOUT, 255: maximum consecutive wait cycles on the memory port before a bus error; 0 disables the timeout.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- instr  in  32  instruction register contents; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_en  out  1  PC load enable.
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut register, 2 = jump address.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B input: 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- alu_op  out  4  mips.h ALU code.
- state  out  4  current state, for debug.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky; set when an unsupported instruction is decoded.
- bus_error  out  1  sticky; set on memory timeout.
- retired  out  1  one-cycle pulse when an instruction completes.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15.
- Outputs not listed for a state are 0.
- **FETCH**
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0.
  - ir_write and pc_en are 1 only in the cycle with mem_ready=1; that cycle moves to DECODE.
- **DECODE**
  - Drives alu_src_a=0, alu_src_b=3, alu_op=add, which precomputes the branch target into ALUOut.
  - Dispatch on instr[31:26]:
    - 0x00 → EXEC when funct is 0x20, 0x22, 0x24, 0x25 or 0x2a; instr==0 → HALT with illegal=0; any other funct → HALT with illegal=1.
    - 0x23 or 0x2b → MEMADR.
    - 0x04 or 0x05 → BRANCH.
    - 0x08 → ADDIEX.
    - 0x02 → JUMP.
    - any other opcode → HALT with illegal=1.
- **MEMADR**: alu_src_a=1, alu_src_b=2, alu_op=add. Next state MEMRD for opcode 0x23, MEMWR for 0x2b.
- **MEMRD**: mem_read=1, iord=1. Stays until mem_ready=1, then MEMWB.
- **MEMWB**: reg_write=1, mem_to_reg=1, reg_dst=0. retired=1; next state FETCH.
- **MEMWR**: mem_write=1, iord=1. Stays until mem_ready=1; that cycle asserts retired and moves to FETCH.
- **EXEC**
  - alu_src_a=1, alu_src_b=0.
  - alu_op from funct: 0x20 add, 0x22 sub, 0x24 AND, 0x25 OR, 0x2a slt.
  - Next state ALUWB.
- **ALUWB**: reg_write=1, reg_dst=1, mem_to_reg=0. retired=1; next state FETCH.
- **ADDIEX**: alu_src_a=1, alu_src_b=2, alu_op=add. Next state ADDIWB.
- **ADDIWB**: reg_write=1, reg_dst=0. retired=1; next state FETCH.
- **BRANCH**
  - alu_src_a=1, alu_src_b=0, alu_op=sub, pc_src=1.
  - pc_en = zero for beq (0x04), ~zero for bne (0x05).
  - retired=1; next state FETCH.
- **JUMP**: pc_src=2, pc_en=1. retired=1; next state FETCH.
- **HALT**: all strobes 0, halted=1. Only reset leaves HALT.
- **Wait counter**
  - Width ceil(log2(TIMEOUT+1)).
  - Increments each cycle in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change and on any cycle with mem_ready=1.
  - When the counter equals TIMEOUT (TIMEOUT≠0) with mem_ready still 0: next state HALT, bus_error=1. No write or IR load happens that cycle.
  - mem_ready=1 in the same cycle as the limit: the completion wins.
- The opcode and funct used in MEMADR, EXEC and BRANCH come from instr, which the datapath holds stable until the next ir_write.

## Timing
- Reset (asynchronous):
  - state=FETCH; illegal, bus_error and the wait counter cleared.
  - While reset is high, ir_write, pc_en, reg_write, mem_write and retired are forced to 0.
  - The other outputs take their FETCH values: mem_read=1, alu_src_b=1, alu_op=add, halted=0.
- Reset asserted mid-MEMWR or mid-MEMRD aborts the access immediately; no write strobe remains.
- Outputs are combinational from state, plus mem_ready, zero and instr where stated; the next state registers on posedge clk.
- Cycle counts with mem_ready=1 on the first request:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3.
  - Each wait cycle adds 1.
- retired pulses exactly once per completed instruction, in its final cycle; it never pulses in HALT.

## Test plan
- Word 0x8C080004 (lw), mem_ready always 1 → states 0,1,2,3,4 over 5 cycles; iord=1 in MEMRD; reg_write=1 with mem_to_reg=1 in cycle 5; one retired pulse.
- FETCH with mem_ready low for 3 cycles → ir_write and pc_en low for 3 cycles, high for exactly 1 cycle, then DECODE.
- 0x10000003 (beq) with zero=1 → pc_en=1, pc_src=1 in BRANCH; with zero=0 → pc_en=0. 0x14000003 (bne) → the inverse.
- Opcode 0x3F → HALT, illegal=1, halted=1, no further strobes; instr=0 → HALT with illegal=0; reset → FETCH with flags cleared.
- TIMEOUT=4, mem_ready held 0 in MEMRD → HALT after 4 wait cycles, bus_error=1, reg_write never asserted.
- Reset asserted in MEMWR with mem_ready=0 → mem_write drops without waiting for a clock edge; state=0; after release, FETCH resumes with mem_read=1.
